// File: rtl/retire_monitor.sv
// ---------------------------------------------------------------------------
// retire_monitor
//   Watches the retirement stream of a core. It counts RUN cycles, retired
//   instructions, control instructions and mispredictions, with saturating
//   counters. It detects the end of a test when one PC retires repeatedly
//   (loop), and it detects a hang when retirements stop (watchdog). It also
//   flags a mispredict strobe that arrives without a retiring control
//   instruction.
//
//   Optional feature (macro RETIRE_MONITOR_HIST_EN): an 8-entry PC-history
//   shift buffer, read combinationally through i_hist_idx. When the macro is
//   not defined, no history is stored and o_hist_pc is tied to 0.
//
// Parameters
//   WDOG_CYCLES   RUN cycles without a retirement before a hang is declared
//   LOOP_COUNT    consecutive retirements of one PC that mark end of test
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset
//   i_pc_debug     PC of the instruction retiring this cycle
//   i_insn_vld     one instruction retires this cycle
//   i_ctrl         retiring instruction is a branch/jump
//   i_mispred      retiring control instruction was mispredicted
//   i_hist_idx     history read index, 0 = most recent retirement
//   o_cycle_cnt    RUN-state cycle count
//   o_retire_cnt   retired instruction count
//   o_ctrl_cnt     retired control instruction count
//   o_mispred_cnt  mispredicted control instruction count
//   o_last_pc      PC of the most recent retirement
//   o_hist_pc      history entry selected by i_hist_idx
//   o_done         loop detected (sticky)
//   o_hang         watchdog expired (sticky)
//   o_proto_err    mispredict without a retiring control instruction (sticky)
// ---------------------------------------------------------------------------
module retire_monitor #(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned LOOP_COUNT  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_debug,
  input  logic        i_insn_vld,
  input  logic        i_ctrl,
  input  logic        i_mispred,
  input  logic [2:0]  i_hist_idx,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_retire_cnt,
  output logic [31:0] o_ctrl_cnt,
  output logic [31:0] o_mispred_cnt,
  output logic [31:0] o_last_pc,
  output logic [31:0] o_hist_pc,
  output logic        o_done,
  output logic        o_hang,
  output logic        o_proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HANG = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] cycle_cnt_r, cycle_cnt_next_s;
  logic [31:0] retire_cnt_r, retire_cnt_next_s;
  logic [31:0] ctrl_cnt_r, ctrl_cnt_next_s;
  logic [31:0] mispred_cnt_r, mispred_cnt_next_s;
  logic [31:0] last_pc_r, last_pc_next_s;
  logic [31:0] streak_r, streak_next_s;
  logic [31:0] wdog_r, wdog_next_s;
  logic        done_r, done_next_s;
  logic        hang_r, hang_next_s;
  logic        proto_err_r, proto_err_next_s;
  logic        retire_s;
  logic        proto_ev_s;
  logic [31:0] streak_cand_s;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A retirement is counted only while the monitor is still live.
  assign retire_s      = i_insn_vld & ((state_r == ST_IDLE) | (state_r == ST_RUN));
  assign streak_cand_s = (i_pc_debug == last_pc_r) ? streak_r + 32'd1 : 32'd1;
  assign proto_ev_s    = i_mispred & ~(i_insn_vld & i_ctrl);

  // Next-state and next-value logic for the FSM and all counters.
  always_comb begin
    state_next_s       = state_r;
    cycle_cnt_next_s   = cycle_cnt_r;
    retire_cnt_next_s  = retire_cnt_r;
    ctrl_cnt_next_s    = ctrl_cnt_r;
    mispred_cnt_next_s = mispred_cnt_r;
    last_pc_next_s     = last_pc_r;
    streak_next_s      = streak_r;
    wdog_next_s        = wdog_r;
    done_next_s        = done_r;
    hang_next_s        = hang_r;
    proto_err_next_s   = proto_err_r;

    // While still idle, only the cycle carrying the first retirement may
    // raise the protocol error; the terminal states keep watching.
    if ((state_r != ST_IDLE) || i_insn_vld) begin
      proto_err_next_s = proto_err_r | proto_ev_s;
    end else begin
      proto_err_next_s = proto_err_r;
    end

    // The cycle counter starts at 1 on the IDLE->RUN edge.
    if (retire_s || (state_r == ST_RUN)) begin
      cycle_cnt_next_s = sat_inc(cycle_cnt_r);
    end else begin
      cycle_cnt_next_s = cycle_cnt_r;
    end

    if (retire_s) begin
      retire_cnt_next_s = sat_inc(retire_cnt_r);
      if (i_ctrl) begin
        ctrl_cnt_next_s = sat_inc(ctrl_cnt_r);
      end else begin
        ctrl_cnt_next_s = ctrl_cnt_r;
      end
      if (i_ctrl && i_mispred) begin
        mispred_cnt_next_s = sat_inc(mispred_cnt_r);
      end else begin
        mispred_cnt_next_s = mispred_cnt_r;
      end
      last_pc_next_s = i_pc_debug;
      streak_next_s  = streak_cand_s;
      wdog_next_s    = 32'd0;
    end else begin
      streak_next_s = streak_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (retire_s) begin
          if (streak_cand_s >= 32'(LOOP_COUNT)) begin
            state_next_s = ST_DONE;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (retire_s) begin
          if (streak_cand_s >= 32'(LOOP_COUNT)) begin
            state_next_s = ST_DONE;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          wdog_next_s = wdog_r + 32'd1;
          if ((wdog_r + 32'd1) >= 32'(WDOG_CYCLES)) begin
            state_next_s = ST_HANG;
            hang_next_s  = 1'b1;
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      ST_DONE: state_next_s = ST_DONE;
      ST_HANG: state_next_s = ST_HANG;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and counter registers; reset wins over every other update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      cycle_cnt_r   <= 32'd0;
      retire_cnt_r  <= 32'd0;
      ctrl_cnt_r    <= 32'd0;
      mispred_cnt_r <= 32'd0;
      last_pc_r     <= 32'd0;
      streak_r      <= 32'd0;
      wdog_r        <= 32'd0;
      done_r        <= 1'b0;
      hang_r        <= 1'b0;
      proto_err_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cycle_cnt_r   <= cycle_cnt_next_s;
      retire_cnt_r  <= retire_cnt_next_s;
      ctrl_cnt_r    <= ctrl_cnt_next_s;
      mispred_cnt_r <= mispred_cnt_next_s;
      last_pc_r     <= last_pc_next_s;
      streak_r      <= streak_next_s;
      wdog_r        <= wdog_next_s;
      done_r        <= done_next_s;
      hang_r        <= hang_next_s;
      proto_err_r   <= proto_err_next_s;
    end
  end

`ifdef RETIRE_MONITOR_HIST_EN
  logic [31:0] hist_r [8];

  // History shift buffer: entry 0 always holds the newest retired PC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) hist_r[i] <= 32'd0;
    end else if (retire_s) begin
      hist_r[0] <= i_pc_debug;
      for (int i = 1; i < 8; i++) hist_r[i] <= hist_r[i-1];
    end
  end

  assign o_hist_pc = hist_r[i_hist_idx];
`else
  logic unused_hist_idx_s;
  assign unused_hist_idx_s = ^i_hist_idx;
  assign o_hist_pc         = 32'd0;
`endif

  assign o_cycle_cnt   = cycle_cnt_r;
  assign o_retire_cnt  = retire_cnt_r;
  assign o_ctrl_cnt    = ctrl_cnt_r;
  assign o_mispred_cnt = mispred_cnt_r;
  assign o_last_pc     = last_pc_r;
  assign o_done        = done_r;
  assign o_hang        = hang_r;
  assign o_proto_err   = proto_err_r;

endmodule

// File: tb/tb_retire_monitor.sv
// ---------------------------------------------------------------------------
// tb_retire_monitor
//   Self-checking bench for retire_monitor (WDOG_CYCLES=16, LOOP_COUNT=4).
//   Directed scenarios plus randomized episodes checked against a reference
//   model that keeps the list of retired PCs and derives streak, history and
//   watchdog from it.
// ---------------------------------------------------------------------------
module tb_retire_monitor;
  localparam int WDOG = 16;
  localparam int LOOP = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_pc_debug = 32'd0;
  logic        i_insn_vld = 1'b0;
  logic        i_ctrl = 1'b0;
  logic        i_mispred = 1'b0;
  logic [2:0]  i_hist_idx = 3'd0;
  logic [31:0] o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt;
  logic [31:0] o_last_pc, o_hist_pc;
  logic        o_done, o_hang, o_proto_err;

  int checks = 0;
  int failures = 0;

  retire_monitor #(.WDOG_CYCLES(WDOG), .LOOP_COUNT(LOOP)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_debug(i_pc_debug),
    .i_insn_vld(i_insn_vld), .i_ctrl(i_ctrl), .i_mispred(i_mispred),
    .i_hist_idx(i_hist_idx), .o_cycle_cnt(o_cycle_cnt),
    .o_retire_cnt(o_retire_cnt), .o_ctrl_cnt(o_ctrl_cnt),
    .o_mispred_cnt(o_mispred_cnt), .o_last_pc(o_last_pc),
    .o_hist_pc(o_hist_pc), .o_done(o_done), .o_hang(o_hang),
    .o_proto_err(o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  bit          m_started, m_done, m_hang, m_perr;
  longint      m_cycles, m_ret, m_ctrl, m_mis;
  int          m_since;
  logic [31:0] m_pcs[$];

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic int run_len();
    int n = 0;
    for (int i = m_pcs.size() - 1; i >= 0; i--) begin
      if (m_pcs[i] == m_pcs[m_pcs.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_last();
    return (m_pcs.size() == 0) ? 32'd0 : m_pcs[m_pcs.size()-1];
  endfunction

  function automatic logic [31:0] exp_hist(input int idx);
`ifdef RETIRE_MONITOR_HIST_EN
    return (idx < m_pcs.size()) ? m_pcs[m_pcs.size()-1-idx] : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_step(input bit rst, input logic [31:0] pc,
                            input bit vld, input bit ctrl, input bit mis);
    if (rst) begin
      m_started = 0; m_done = 0; m_hang = 0; m_perr = 0;
      m_cycles = 0; m_ret = 0; m_ctrl = 0; m_mis = 0; m_since = 0;
      m_pcs.delete();
      return;
    end
    if (mis && !(vld && ctrl) && (m_started || vld)) m_perr = 1;
    if (m_done || m_hang) return;
    if (!m_started && !vld) return;
    m_started = 1;
    m_cycles++;
    if (vld) begin
      m_ret++;
      if (ctrl) m_ctrl++;
      if (ctrl && mis) m_mis++;
      m_pcs.push_back(pc);
      m_since = 0;
      if (run_len() >= LOOP) m_done = 1;
    end else begin
      m_since++;
      if (m_since >= WDOG) m_hang = 1;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic drive(input bit rst, input logic [31:0] pc,
                       input bit vld, input bit ctrl, input bit mis);
    i_reset = rst; i_pc_debug = pc; i_insn_vld = vld; i_ctrl = ctrl; i_mispred = mis;
    @(posedge i_clk);
    model_step(rst, pc, vld, ctrl, mis);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
    i_hist_idx = 3'd0; #1;
    checks++;
    if ({o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt, o_last_pc, o_hist_pc,
         o_done, o_hang, o_proto_err} !== 195'd0) begin
      failures++;
      $display("FAIL reset_state: got cyc=%h ret=%h ctl=%h mis=%h last=%h hist=%h d/h/p=%b%b%b required all 0",
               o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt, o_last_pc, o_hist_pc,
               o_done, o_hang, o_proto_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cycle_cnt !== 32'd0) begin
      failures++; $display("FAIL idle_no_cycles: got %0d required 0", o_cycle_cnt);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h8, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_retire_cnt, o_cycle_cnt, o_last_pc, o_done} !== {32'd3, 32'd3, 32'h8, 1'b0}) begin
      failures++;
      $display("FAIL basic_retire: got ret=%0d cyc=%0d last=%h done=%b required 3 3 8 0",
               o_retire_cnt, o_cycle_cnt, o_last_pc, o_done);
    end
  endtask

  task automatic test_ctrl();
    do_reset();
    drive(1'b0, 32'h10, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 32'h14, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({o_ctrl_cnt, o_mispred_cnt, o_proto_err} !== {32'd2, 32'd1, 1'b0}) begin
      failures++;
      $display("FAIL ctrl_counts: got ctl=%0d mis=%0d perr=%b required 2 1 0",
               o_ctrl_cnt, o_mispred_cnt, o_proto_err);
    end
    drive(1'b0, 32'h18, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({o_proto_err, o_mispred_cnt, o_retire_cnt} !== {1'b1, 32'd1, 32'd3}) begin
      failures++;
      $display("FAIL proto_err: got perr=%b mis=%0d ret=%0d required 1 1 3",
               o_proto_err, o_mispred_cnt, o_retire_cnt);
    end
  endtask

  task automatic test_loop();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
      checks++;
      if (o_done !== (k == 3)) begin
        failures++; $display("FAIL loop_done_%0d: got %b required %b", k, o_done, (k == 3));
      end
      if (k < 3) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) drive(1'b0, 32'h44 + 32'(k), 1'b1, 1'b1, 1'b0);
    checks++;
    if ({o_retire_cnt, o_cycle_cnt, o_ctrl_cnt, o_last_pc, o_done} !==
        {32'd4, 32'd7, 32'd0, 32'h40, 1'b1}) begin
      failures++;
      $display("FAIL loop_frozen: got ret=%0d cyc=%0d ctl=%0d last=%h done=%b required 4 7 0 40 1",
               o_retire_cnt, o_cycle_cnt, o_ctrl_cnt, o_last_pc, o_done);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WDOG - 1; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_hang !== 1'b0) begin
      failures++; $display("FAIL wdog_early: got %b required 0", o_hang);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_hang !== 1'b1) begin
      failures++; $display("FAIL wdog_expire: got %b required 1", o_hang);
    end
    drive(1'b0, 32'h84, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_hang, o_cycle_cnt, o_retire_cnt} !== {1'b1, 32'd17, 32'd1}) begin
      failures++;
      $display("FAIL hang_frozen: got hang=%b cyc=%0d ret=%0d required 1 17 1",
               o_hang, o_cycle_cnt, o_retire_cnt);
    end
    do_reset();
    drive(1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WDOG - 2; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h84, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_hang, o_cycle_cnt} !== {1'b0, 32'd21}) begin
      failures++; $display("FAIL wdog_cleared: got hang=%b cyc=%0d required 0 21", o_hang, o_cycle_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 1; i <= 50; i++) drive(1'b0, 32'(i * 4), 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_retire_cnt !== 32'd50) begin
      failures++; $display("FAIL pre_reset_count: got %0d required 50", o_retire_cnt);
    end
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    i_hist_idx = 3'd0; #1;
    checks++;
    if ({o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt, o_last_pc, o_hist_pc,
         o_done, o_hang, o_proto_err} !== 195'd0) begin
      failures++;
      $display("FAIL mid_run_reset: got cyc=%0d ret=%0d ctl=%0d last=%h hist=%h required all 0",
               o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_last_pc, o_hist_pc);
    end
    drive(1'b0, 32'h300, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_retire_cnt, o_cycle_cnt, o_last_pc} !== {32'd1, 32'd1, 32'h300}) begin
      failures++;
      $display("FAIL restart_count: got ret=%0d cyc=%0d last=%h required 1 1 300",
               o_retire_cnt, o_cycle_cnt, o_last_pc);
    end
  endtask

  task automatic test_history();
    logic [31:0] exp0, exp7;
`ifdef RETIRE_MONITOR_HIST_EN
    exp0 = 32'h124; exp7 = 32'h108;
`else
    exp0 = 32'h0; exp7 = 32'h0;
`endif
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
    i_hist_idx = 3'd0; #1;
    checks++;
    if (o_hist_pc !== exp0) begin
      failures++; $display("FAIL hist_idx0: got %h required %h", o_hist_pc, exp0);
    end
    i_hist_idx = 3'd7; #1;
    checks++;
    if (o_hist_pc !== exp7) begin
      failures++; $display("FAIL hist_idx7: got %h required %h", o_hist_pc, exp7);
    end
  endtask

  task automatic test_random();
    int vprob, pool;
    int probs[3] = '{10, 50, 95};
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      vprob = probs[$urandom_range(0, 2)];
      pool  = $urandom_range(1, 3);
      for (int c = 0; c < 300; c++) begin
        i_hist_idx = 3'($urandom_range(0, 7));
        drive(($urandom_range(0, 199) == 0),
              32'h1000 + 32'(4 * $urandom_range(0, pool - 1)),
              ($urandom_range(0, 99) < vprob),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
        checks++;
        if ({o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt} !==
            {sat32(m_cycles), sat32(m_ret), sat32(m_ctrl), sat32(m_mis)}) begin
          failures++;
          $display("FAIL rand_counts ep%0d c%0d: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                   ep, c, o_cycle_cnt, o_retire_cnt, o_ctrl_cnt, o_mispred_cnt,
                   m_cycles, m_ret, m_ctrl, m_mis);
        end
        checks++;
        if ({o_last_pc, o_hist_pc} !== {exp_last(), exp_hist(int'(i_hist_idx))}) begin
          failures++;
          $display("FAIL rand_pc ep%0d c%0d: got last=%h hist=%h required %h %h",
                   ep, c, o_last_pc, o_hist_pc, exp_last(), exp_hist(int'(i_hist_idx)));
        end
        checks++;
        if ({o_done, o_hang, o_proto_err} !== {m_done, m_hang, m_perr}) begin
          failures++;
          $display("FAIL rand_flags ep%0d c%0d: got d/h/p=%b%b%b required %b%b%b",
                   ep, c, o_done, o_hang, o_proto_err, m_done, m_hang, m_perr);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_ctrl();
    test_loop();
    test_watchdog();
    test_reset_mid_run();
    test_history();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 Parameter WDOG_CYCLES, default 1024: consecutive RUN cycles without a retirement before a hang is declared.
REQ-002 Parameter LOOP_COUNT, default 4: consecutive retirements of one PC that mark end of test.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_pc_debug  input  32  PC of the instruction retiring this cycle (core o_pc_debug).
REQ-006 i_insn_vld  input  1  one instruction retires this cycle (core o_insn_vld).
REQ-007 i_ctrl  input  1  retiring instruction is a branch/jump (core o_ctrl).
REQ-008 i_mispred  input  1  retiring control instruction was mispredicted (core o_mispred).
REQ-009 i_hist_idx  input  3  PC-history read index; 0 = most recent retirement.
REQ-010 o_cycle_cnt  output  32  RUN-state cycle count.
REQ-011 o_retire_cnt  output  32  retired-instruction count.
REQ-012 o_ctrl_cnt  output  32  retired control-instruction count.
REQ-013 o_mispred_cnt  output  32  mispredicted control-instruction count.
REQ-014 o_last_pc  output  32  PC of the most recent retirement.
REQ-015 o_hist_pc  output  32  PC-history entry selected by i_hist_idx.
REQ-016 o_done  output  1  end-of-test loop detected; sticky.
REQ-017 o_hang  output  1  watchdog expired; sticky.
REQ-018 o_proto_err  output  1  i_mispred seen without i_ctrl&i_insn_vld; sticky.

Function
REQ-019 FSM states IDLE, RUN, DONE, HANG; IDLE after reset.
REQ-020 IDLE->RUN on first cycle with i_insn_vld=1; that retirement is counted and the RUN cycle counter is 1 after that edge.
REQ-021 In RUN, o_cycle_cnt increments by 1 every cycle.
REQ-022 Counters increment one clock after sampling: retire on i_insn_vld; ctrl on i_insn_vld&i_ctrl; mispred on i_insn_vld&i_ctrl&i_mispred.
REQ-023 All counters saturate at 32'hFFFF_FFFF; never wrap.
REQ-024 Loop detection: streak=1 on a retirement whose PC differs from o_last_pc, streak+1 on same PC; cycles with i_insn_vld=0 leave streak unchanged.
REQ-025 RUN->DONE when streak reaches LOOP_COUNT; that retirement is counted; o_done=1 the following cycle.
REQ-026 Watchdog counts RUN cycles with i_insn_vld=0, clears on any retirement; RUN->HANG when it reaches WDOG_CYCLES; o_hang=1 the next cycle.
REQ-027 DONE and HANG are terminal until reset; all counters, o_last_pc and history freeze; inputs ignored.
REQ-028 i_mispred=1 while (i_insn_vld&i_ctrl)=0 sets o_proto_err in any state except IDLE before first retirement; mispred counter not incremented.
REQ-029 IDLE cycles do not advance the watchdog or o_cycle_cnt.

Reset
REQ-030 i_reset=1 at any clock edge, including mid-RUN, forces IDLE and clears every counter, streak, watchdog, o_last_pc, history, o_done, o_hang, o_proto_err to 0.
REQ-031 i_reset dominates a simultaneous retirement, loop completion or watchdog expiry.

Configuration
REQ-032 Macro RETIRE_MONITOR_HIST_EN defined: 8-entry PC-history shift buffer; each counted retirement pushes i_pc_debug into entry 0; o_hist_pc = entry[i_hist_idx] combinationally; unwritten entries read 0.
REQ-033 Macro RETIRE_MONITOR_HIST_EN undefined: no history storage; o_hist_pc tied to 0; all other behaviour unchanged.

Verification
REQ-034 Reset, 10 idle cycles, retire PCs 0x0,0x4,0x8 on consecutive cycles -> retire_cnt=3, cycle_cnt=3, last_pc=0x8, done=0.
REQ-035 Retire 0x10 with ctrl=1 mispred=1, then 0x14 ctrl=1 mispred=0 -> ctrl_cnt=2, mispred_cnt=1, proto_err=0; then mispred=1 with ctrl=0 -> proto_err=1, mispred_cnt stays 1.
REQ-036 Retire 0x40 four times separated by idle cycles -> done=1 one cycle after 4th; retire_cnt includes all 4; further retirements leave counters frozen.
REQ-037 WDOG_CYCLES=16: one retirement then 16 idle cycles -> hang=1; retirement at idle cycle 15 instead -> hang stays 0.
REQ-038 Assert i_reset mid-RUN with retire_cnt=50 -> all outputs 0 next cycle, state IDLE, next retirement restarts counts from 1.
REQ-039 With RETIRE_MONITOR_HIST_EN, retire 0x100..0x124 step 4 (10 PCs) -> hist_idx 0 reads 0x124, idx 7 reads 0x108; without macro, o_hist_pc=0.
